// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, toggle count and divider helper.
// Used by both the SPI master and the SPI slave.
package spi_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CS_SETUP  = 3'd1;
  localparam logic [2:0] ST_SCLK_WAIT = 3'd2;
  localparam logic [2:0] ST_SCLK_EDGE = 3'd3;
  localparam logic [2:0] ST_LAST_HALF = 3'd4;
  localparam logic [2:0] ST_ACK       = 3'd5;
  localparam logic [2:0] ST_HOLD      = 3'd6;

  // sclk edges per byte: 8 bits, two edges each
  localparam logic [4:0] SPI_TOGGLES = 5'd16;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    CS_SETUP  = ST_CS_SETUP,
    SCLK_WAIT = ST_SCLK_WAIT,
    SCLK_EDGE = ST_SCLK_EDGE,
    LAST_HALF = ST_LAST_HALF,
    ACK       = ST_ACK,
    HOLD      = ST_HOLD
  } spi_state_t;

  function automatic logic [15:0] eff_div(input logic [15:0] val);
    return (val == 16'd0) ? 16'd1 : val;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// SPI master bus bundle: request/ack handshake plus the four SPI wires.
// hold_cs exists only when SPI_MASTER_BURST_EN is defined.
interface spi_master_if;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [15:0] clk_div_val;
  logic        wr_req;
  logic [7:0]  data_tx;
  logic        busy;
  logic        wr_ack;
  logic [7:0]  data_rx;
`ifdef SPI_MASTER_BURST_EN
  logic        hold_cs;
`endif

  modport master (
    output cs, sclk, mosi, busy, wr_ack, data_rx,
`ifdef SPI_MASTER_BURST_EN
    input  hold_cs,
`endif
    input  miso, clk_div_val, wr_req, data_tx
  );

  modport slave (
    input  cs, sclk, mosi, busy, wr_ack, data_rx,
`ifdef SPI_MASTER_BURST_EN
    output hold_cs,
`endif
    output miso, clk_div_val, wr_req, data_tx
  );
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period counter: strobes o_tick every i_div cycles while enabled, toggles sclk on ticks.
// Latency: first tick i_div cycles after enable; sclk parks at CPOL while disabled.
// Backpressure: none, free-running while i_en is high.
module spi_clk_gen #(
  parameter logic CPOL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_tgl_en,
  input  logic [15:0] i_div,
  output logic        o_tick,
  output logic        o_sclk
);
  logic [15:0] r_cnt;
  logic        r_sclk;

  assign o_tick = i_en && (r_cnt == (i_div - 16'd1));
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt  <= 16'd0;
      r_sclk <= CPOL;
    end else begin
      r_cnt <= o_tick ? 16'd0 : r_cnt + 16'd1;
      if (o_tick && i_tgl_en) r_sclk <= ~r_sclk;
    end
  end
endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master (CPOL/CPHA parameters); optional CS burst hold via SPI_MASTER_BURST_EN.
// Latency: wr_ack 18*D cycles after accept (17*D when accepted from HOLD).
// Backpressure: wr_req accepted only when not busy; requests while busy are dropped.
module spi_master
  import spi_pkg::*;
#(
  parameter logic CPOL = 1'b1,
  parameter logic CPHA = 1'b1
) (
  input logic          sys_clk,
  input logic          sys_rst,
  spi_master_if.master bus
);
  spi_state_t  r_state;
  logic [15:0] r_div;
  logic [4:0]  r_tgl;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic        r_cs;
  logic        r_busy;
  logic        r_ack;
`ifdef SPI_MASTER_BURST_EN
  logic        r_hold;
`endif

  logic       w_tick;
  logic       w_sclk;
  logic       w_en;
  logic       w_tgl_en;
  logic       w_accept;
  logic       w_samp;
  logic       w_shift;
  logic [4:0] w_n;

  assign w_en     = (r_state != IDLE) && (r_state != ACK) && (r_state != HOLD);
  assign w_tgl_en = (r_state == SCLK_WAIT) || (r_state == SCLK_EDGE);
  assign w_accept = bus.wr_req && ((r_state == IDLE) || (r_state == HOLD));
  // w_n is the index of the toggle happening at this tick; CPHA picks sample parity
  assign w_n      = r_tgl + 5'd1;
  assign w_samp   = w_n[0] ^ CPHA;
  assign w_shift  = !w_samp && (w_n >= 5'd2) && (w_n <= 5'd15);

  spi_clk_gen #(.CPOL(CPOL)) u_clk_gen (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_en    (w_en),
    .i_tgl_en(w_tgl_en),
    .i_div   (r_div),
    .o_tick  (w_tick),
    .o_sclk  (w_sclk)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_div   <= 16'd0;
      r_tgl   <= 5'd0;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      r_hold  <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
      if (w_accept) begin
        r_div  <= eff_div(bus.clk_div_val);
        r_tx   <= bus.data_tx;
        r_rx   <= 8'h00;
        r_tgl  <= 5'd0;
        r_cs   <= 1'b0;
        r_busy <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
        r_hold <= bus.hold_cs;
`endif
      end
      case (r_state)
        IDLE: if (bus.wr_req) r_state <= CS_SETUP;
`ifdef SPI_MASTER_BURST_EN
        HOLD: begin
          if (bus.wr_req) begin
            r_state <= SCLK_WAIT;
          end else if (!bus.hold_cs) begin
            r_state <= IDLE;
            r_cs    <= 1'b1;
          end
        end
`endif
        CS_SETUP: if (w_tick) r_state <= SCLK_WAIT;
        SCLK_WAIT, SCLK_EDGE: begin
          if (w_tick) begin
            r_tgl <= w_n;
            if (w_samp)  r_rx <= {r_rx[6:0], bus.miso};
            if (w_shift) r_tx <= {r_tx[6:0], 1'b0};
            r_state <= (w_n == SPI_TOGGLES) ? LAST_HALF : SCLK_EDGE;
          end else if (r_state == SCLK_EDGE) begin
            r_state <= SCLK_WAIT;
          end
        end
        LAST_HALF: begin
          if (w_tick) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
            r_cs    <= !r_hold;
`else
            r_cs    <= 1'b1;
`endif
          end
        end
        ACK: begin
          r_busy <= 1'b0;
          r_tgl  <= 5'd0;
`ifdef SPI_MASTER_BURST_EN
          r_state <= r_hold ? HOLD : IDLE;
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cs      = r_cs;
  assign bus.sclk    = w_sclk;
  assign bus.mosi    = r_tx[7];
  assign bus.busy    = r_busy;
  assign bus.wr_ack  = r_ack;
  assign bus.data_rx = r_rx;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (mode 3 loopback, mode 0 with a slave model)
// checked every cycle against a timing-formula model plus literal spot checks.
module tb_spi_master;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_en  = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] s_reg = 8'h00;

  always #5 sys_clk = ~sys_clk;

  spi_master_if ifa ();
  spi_master_if ifb ();

  spi_master #(.CPOL(1'b1), .CPHA(1'b1)) dut_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ifa));
  spi_master #(.CPOL(1'b0), .CPHA(1'b0)) dut_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ifb));

  assign ifa.miso = ifa.mosi;
  assign ifb.miso = s_reg[7];

  // mode-0 slave: loads at cs fall, shifts out on falling sclk
  always @(negedge ifb.cs) s_reg <= slave_byte;
  always @(negedge ifb.sclk) if (ifb.cs === 1'b0) s_reg <= {s_reg[6:0], 1'b0};

  function automatic logic cs_of(input int i);   return (i == 0) ? ifa.cs     : ifb.cs;     endfunction
  function automatic logic sclk_of(input int i); return (i == 0) ? ifa.sclk   : ifb.sclk;   endfunction
  function automatic logic mosi_of(input int i); return (i == 0) ? ifa.mosi   : ifb.mosi;   endfunction
  function automatic logic busy_of(input int i); return (i == 0) ? ifa.busy   : ifb.busy;   endfunction
  function automatic logic ack_of(input int i);  return (i == 0) ? ifa.wr_ack : ifb.wr_ack; endfunction
  function automatic logic [7:0] rx_of(input int i); return (i == 0) ? ifa.data_rx : ifb.data_rx; endfunction
  function automatic int cpol_of(input int i); return (i == 0) ? 1 : 0; endfunction
  function automatic int cpha_of(input int i); return (i == 0) ? 1 : 0; endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  task automatic set_in(input int i, input logic wr, input logic [7:0] tx, input logic [15:0] div,
                        input logic hold);
    if (i == 0) begin
      ifa.wr_req = wr; ifa.data_tx = tx; ifa.clk_div_val = div;
`ifdef SPI_MASTER_BURST_EN
      ifa.hold_cs = hold;
`endif
    end else begin
      ifb.wr_req = wr; ifb.data_tx = tx; ifb.clk_div_val = div;
`ifdef SPI_MASTER_BURST_EN
      ifb.hold_cs = hold;
`endif
    end
  endtask

  // Model: each transfer is a fixed timeline from its accept edge t0
  bit         m_act[2], m_hold[2], m_hreq[2];
  int         m_t0[2], m_d[2], m_pre[2], m_n[2];
  logic [7:0] m_tx[2], m_exp[2], m_last[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_hold[i] = 0; m_hreq[i] = 0; m_last[i] = 8'h00;
    end
    forever begin
      @(posedge sys_clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        logic wr, hold;
        logic [15:0] div;
        logic [7:0] tx;
        wr   = (i == 0) ? ifa.wr_req : ifb.wr_req;
        div  = (i == 0) ? ifa.clk_div_val : ifb.clk_div_val;
        tx   = (i == 0) ? ifa.data_tx : ifb.data_tx;
`ifdef SPI_MASTER_BURST_EN
        hold = (i == 0) ? ifa.hold_cs : ifb.hold_cs;
`else
        hold = 1'b0;
`endif
        if (sys_rst) begin
          m_act[i] = 0; m_hold[i] = 0; m_last[i] = 8'h00;
        end else if (!m_act[i] && wr) begin
          m_act[i]  = 1;
          m_t0[i]   = cyc;
          m_d[i]    = (div == 16'd0) ? 1 : int'(div);
          m_pre[i]  = m_hold[i] ? 0 : m_d[i];
          m_n[i]    = m_pre[i] + 17 * m_d[i];
          m_tx[i]   = tx;
          m_exp[i]  = (i == 0) ? tx : slave_byte;
          m_hreq[i] = hold;
          m_hold[i] = 0;
        end else if (m_act[i] && cyc == m_t0[i] + m_n[i] + 1) begin
          m_act[i]  = 0;
          m_hold[i] = m_hreq[i];
          m_last[i] = m_exp[i];
        end else if (!m_act[i] && m_hold[i] && !hold) begin
          m_hold[i] = 0;
        end
      end
      #1;
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          if (m_act[i]) begin
            int k, cnt, s;
            k   = cyc - m_t0[i];
            cnt = (k < m_pre[i]) ? 0 : (k - m_pre[i]) / m_d[i];
            if (cnt > 16) cnt = 16;
            if (cpha_of(i) == 1) s = (cnt >= 3) ? (cnt - 1) / 2 : 0;
            else                 s = (cnt / 2 > 7) ? 7 : cnt / 2;
            chk("busy", i, int'(busy_of(i)), 1);
            chk("wr_ack", i, int'(ack_of(i)), (k == m_n[i]) ? 1 : 0);
            chk("cs", i, int'(cs_of(i)), (k == m_n[i] && !m_hreq[i]) ? 1 : 0);
            chk("sclk", i, int'(sclk_of(i)), (cpol_of(i) + cnt) % 2);
            chk("mosi", i, int'(mosi_of(i)), int'(m_tx[i][7 - s]));
            if (k == m_n[i]) chk("data_rx", i, int'(rx_of(i)), int'(m_exp[i]));
          end else begin
            chk("idle_busy", i, int'(busy_of(i)), 0);
            chk("idle_ack", i, int'(ack_of(i)), 0);
            chk("idle_cs", i, int'(cs_of(i)), m_hold[i] ? 0 : 1);
            chk("idle_sclk", i, int'(sclk_of(i)), cpol_of(i));
            chk("idle_rx", i, int'(rx_of(i)), int'(m_last[i]));
          end
        end
      end
    end
  end

  task automatic start(input int i, input logic [7:0] tx, input logic [15:0] div, input logic hold,
                       output int t0);
    @(negedge sys_clk);
    set_in(i, 1'b1, tx, div, hold);
    @(negedge sys_clk);
    set_in(i, 1'b0, tx, div, hold);
    t0 = cyc;
  endtask

  task automatic wait_ack(input int i, input int t0, output int ack_k, output int lows, output int tgl);
    logic ps;
    ack_k = -1;
    lows  = (cs_of(i) == 1'b0) ? 1 : 0;
    tgl   = 0;
    ps    = sclk_of(i);
    for (int n = 0; n < 2000; n++) begin
      @(negedge sys_clk);
      if (cs_of(i) == 1'b0) lows++;
      if (sclk_of(i) !== ps) tgl++;
      ps = sclk_of(i);
      if (ack_of(i)) begin
        ack_k = cyc - t0;
        break;
      end
    end
    if (ack_k < 0) chk("ack_timeout", i, 0, 1);
  endtask

  initial begin
    int t0, ak, lo, tg, acks;
    set_in(0, 1'b0, 8'h00, 16'd4, 1'b0);
    set_in(1, 1'b0, 8'h00, 16'd1, 1'b0);
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs", i, int'(cs_of(i)), 1);
      chk("rst_sclk", i, int'(sclk_of(i)), cpol_of(i));
      chk("rst_mosi", i, int'(mosi_of(i)), 0);
      chk("rst_busy", i, int'(busy_of(i)), 0);
      chk("rst_ack", i, int'(ack_of(i)), 0);
      chk("rst_rx", i, int'(rx_of(i)), 0);
    end
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    // mode 3, D=4, loopback
    start(0, 8'hA5, 16'd4, 1'b0, t0);
    wait_ack(0, t0, ak, lo, tg);
    chk("a5_ack_at", 0, ak, 72);
    chk("a5_rx", 0, int'(ifa.data_rx), 'hA5);
    chk("a5_toggles", 0, tg, 16);
    chk("a5_cs_low", 0, lo, 72);

    // mode 0, divider 0 behaves as 1, slave returns 3C
    slave_byte = 8'h3C;
    start(1, 8'h00, 16'd0, 1'b0, t0);
    wait_ack(1, t0, ak, lo, tg);
    chk("3c_ack_at", 1, ak, 18);
    chk("3c_rx", 1, int'(ifb.data_rx), 'h3C);
    chk("3c_toggles", 1, tg, 16);
    slave_byte = 8'h96;
    start(1, 8'h5B, 16'd1, 1'b0, t0);
    wait_ack(1, t0, ak, lo, tg);
    chk("96_ack_at", 1, ak, 18);
    chk("96_rx", 1, int'(ifb.data_rx), 'h96);

    // request while busy is dropped
    start(0, 8'h5A, 16'd2, 1'b0, t0);
    acks = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge sys_clk);
      if (n == 9)  set_in(0, 1'b1, 8'hFF, 16'd2, 1'b0);
      if (n == 10) set_in(0, 1'b0, 8'hFF, 16'd2, 1'b0);
      if (ifa.wr_ack) acks++;
    end
    chk("busy_req_acks", 0, acks, 1);
    chk("busy_req_rx", 0, int'(ifa.data_rx), 'h5A);

    // divider change mid-transfer has no effect
    start(0, 8'hC3, 16'd3, 1'b0, t0);
    repeat (5) @(negedge sys_clk);
    set_in(0, 1'b0, 8'hC3, 16'd1, 1'b0);
    wait_ack(0, t0, ak, lo, tg);
    chk("div_chg_ack_at", 0, ak, 54);
    chk("div_chg_rx", 0, int'(ifa.data_rx), 'hC3);

    // reset mid-transfer, then a clean transfer
    start(0, 8'h81, 16'd4, 1'b0, t0);
    repeat (29) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_cs", 0, int'(ifa.cs), 1);
    chk("abort_sclk", 0, int'(ifa.sclk), 1);
    chk("abort_busy", 0, int'(ifa.busy), 0);
    chk("abort_ack", 0, int'(ifa.wr_ack), 0);
    sys_rst = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (ifa.wr_ack) acks++;
    end
    chk("abort_no_ack", 0, acks, 0);
    start(0, 8'h7E, 16'd4, 1'b0, t0);
    wait_ack(0, t0, ak, lo, tg);
    chk("post_abort_ack_at", 0, ak, 72);
    chk("post_abort_rx", 0, int'(ifa.data_rx), 'h7E);

`ifdef SPI_MASTER_BURST_EN
    start(0, 8'h12, 16'd2, 1'b1, t0);
    wait_ack(0, t0, ak, lo, tg);
    chk("burst1_ack_at", 0, ak, 36);
    chk("burst1_rx", 0, int'(ifa.data_rx), 'h12);
    @(negedge sys_clk);
    chk("hold_cs_low", 0, int'(ifa.cs), 0);
    chk("hold_busy", 0, int'(ifa.busy), 0);
    start(0, 8'h34, 16'd2, 1'b1, t0);
    wait_ack(0, t0, ak, lo, tg);
    chk("burst2_ack_at", 0, ak, 34);
    chk("burst2_rx", 0, int'(ifa.data_rx), 'h34);
    chk("burst2_cs_low", 0, lo, 35);
    @(negedge sys_clk);
    set_in(0, 1'b0, 8'h34, 16'd2, 1'b0);
    @(negedge sys_clk);
    chk("drop_cs", 0, int'(ifa.cs), 1);
    start(0, 8'h55, 16'd2, 1'b0, t0);
    wait_ack(0, t0, ak, lo, tg);
    chk("after_drop_ack_at", 0, ak, 36);
`endif

    repeat (5) @(negedge sys_clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CPOL, default 1'b1, sclk idle level.
REQ-002 SHALL have parameter CPHA, default 1'b1: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: cs output 1, chip select, active-low. sclk output 1, serial clock. mosi output 1, master out. miso input 1, master in.
REQ-006 SHALL have port clk_div_val  input  16  sclk half-period D in sys_clk cycles; a value of 0 is treated as 1.
REQ-007 SHALL have port wr_req  input  1  start a byte transfer.
REQ-008 SHALL have port data_tx  input  8  byte to send, MSB first.
REQ-009 SHALL have ports: busy output 1, transfer in progress. wr_ack output 1, one-cycle done pulse. data_rx output 8, received byte.

Function
REQ-010 SHALL implement states IDLE, CS_SETUP, SCLK_WAIT, SCLK_EDGE, LAST_HALF and ACK.
REQ-011 SHALL, in IDLE, drive cs=1, sclk=CPOL and busy=0.
REQ-012 SHALL accept wr_req only in IDLE, latching data_tx into the tx shifter and clearing the rx shifter at the accept edge t0.
REQ-013 SHALL ignore wr_req while busy; there is no queueing.
REQ-014 SHALL drive cs=0 from t0, hold CS_SETUP for D cycles, then produce 16 sclk toggles spaced D cycles apart.
REQ-015 SHALL hold LAST_HALF for D cycles after the 16th toggle.
REQ-016 SHALL enter ACK at t0+18*D, asserting wr_ack for exactly one cycle and setting cs=1 in the same cycle.
REQ-017 SHALL return to IDLE after ACK.
REQ-018 SHALL, for CPHA=0, present mosi bit7 from t0, sample miso on odd toggles (1,3,…,15) and shift mosi on even toggles (2,…,14).
REQ-019 SHALL, for CPHA=1, shift mosi on odd toggles 3,…,15 (bit7 is valid before toggle 1) and sample miso on even toggles (2,…,16).
REQ-020 SHALL shift received bits in MSB first; data_rx SHALL equal the rx shifter, valid at wr_ack and stable until the next accept.
REQ-021 SHALL keep busy=1 from t0 through ACK inclusive.
REQ-022 SHALL return immediately to IDLE (cs=1, sclk=CPOL, no wr_ack) if sys_rst asserts mid-transfer.
REQ-023 SHALL sample clk_div_val at accept; changes during a transfer SHALL have no effect until the next accept.

Reset
REQ-024 SHALL, on sys_rst=1 at a clock edge, set state=IDLE, cs=1, sclk=CPOL, mosi=0, busy=0, wr_ack=0, data_rx=8'h00 and all counters to 0.

Configuration
REQ-025 SHALL support macro SPI_MASTER_BURST_EN; when defined, SHALL add input hold_cs (1 bit), sampled at accept.
REQ-026 SHALL, with SPI_MASTER_BURST_EN and hold_cs=1, keep cs=0 through ACK and enter state HOLD (cs=0, sclk=CPOL, busy=0) instead of IDLE.
REQ-027 SHALL, in HOLD, treat wr_req as an accept that skips CS_SETUP, giving wr_ack at t0+17*D.
REQ-028 SHALL, in HOLD, treat hold_cs=0 with no wr_req as a request to set cs=1 and go to IDLE on the next cycle.
REQ-029 SHALL, without SPI_MASTER_BURST_EN, omit hold_cs and HOLD, with cs always deasserting at ACK.

Structure
REQ-030 SHALL place the state encoding localparams and the 16-toggle count constant in shared package spi_pkg, also used by spi_slave.
REQ-031 SHALL use one sub-module, spi_clk_gen: a half-period counter that emits the edge strobe and toggles sclk.

Verification
REQ-032 SHALL verify: CPOL=1, CPHA=1, D=4, data_tx=8'hA5, miso looped to mosi -> wr_ack at t0+72, data_rx=8'hA5, 16 sclk toggles, cs low for 72 cycles.
REQ-033 SHALL verify: CPOL=0, CPHA=0, D=1 (and clk_div_val=0) with slave model returning 8'h3C -> data_rx=8'h3C, wr_ack at t0+18.
REQ-034 SHALL verify: wr_req pulsed at t0+10 during a transfer -> ignored, exactly one wr_ack, data_rx unaffected.
REQ-035 SHALL verify: sys_rst at t0+30, D=4 -> next cycle cs=1, sclk=CPOL, busy=0, no wr_ack; a fresh transfer then completes normally.
REQ-036 SHALL verify: SPI_MASTER_BURST_EN, hold_cs=1, bytes 8'h12 then 8'h34, D=2 -> cs stays low between bytes, second wr_ack at t0'+34.
REQ-037 SHALL verify: SPI_MASTER_BURST_EN, hold_cs then dropped in HOLD -> cs=1 on the next cycle and state returns to IDLE.
